johnson_counter_param: RTL and testbench

Parametrised Johnson (twisted-ring) counter with a width generic, up/down direction, enable, synchronous phase load and a terminal-count flag. It produces the raw ring pattern plus a binary phase index and a one-hot phase decode, so downstream logic can use it as a glitch-free multi-phase sequencer. It is the general successor to the fixed 4-bit structural Johnson counter. Optional illegal-state self-correction is compiled in by macro.

---
 rtl/johnson_counter_param.sv | 95 +++++++++
 tb/tb_johnson_counter_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/johnson_counter_param.sv
// johnson_counter_param: parametrised Johnson (twisted-ring) counter with
// up/down stepping, enable, synchronous phase load, binary phase index,
// one-hot phase decode and a combinational terminal-count flag.
// Optional illegal-state self-correction: define JOHNSON_SELF_CORRECT_EN.
module johnson_counter_param #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned PW    = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [PW-1:0]        load_phase,
  output logic [WIDTH-1:0]     q,
  output logic [PW-1:0]        phase,
  output logic [2*WIDTH-1:0]   dec,
  output logic                 tc,
  output logic                 illegal
);

  localparam int unsigned NSTATES = 2 * WIDTH;

  // Legal ring pattern for a phase; out-of-range phases map to all zeros.
  // Phases 0..WIDTH fill ones from the LSB, later phases clear them from the LSB.
  function automatic logic [WIDTH-1:0] pattern_of(input logic [PW-1:0] p);
    logic [WIDTH-1:0] r;
    int unsigned      pv;
    r  = '0;
    pv = 32'(p);
    if (pv < NSTATES) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (pv <= WIDTH) r[i] = (i < pv);
        else             r[i] = (i >= pv - WIDTH);
      end
    end
    return r;
  endfunction

  // Phase index: popcount when the MSB is clear, mirrored when it is set.
  always_comb begin
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < WIDTH; i++) cnt += 32'(q[i]);
    if (q[WIDTH-1]) phase = PW'(NSTATES - cnt);
    else            phase = PW'(cnt);
  end

  // One-hot decode of the phase index.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < NSTATES; i++) dec[i] = (32'(phase) == i);
  end

  // Terminal count: high in the cycle whose next edge wraps in the current direction.
  always_comb begin
    tc = en & ~load & (up ? (phase == PW'(NSTATES - 1)) : (phase == '0));
  end

`ifdef JOHNSON_SELF_CORRECT_EN
  logic legal;

  // A pattern is legal when at most one adjacent bit pair differs.
  always_comb begin
    int unsigned edges;
    edges = 0;
    for (int unsigned i = 0; i + 1 < WIDTH; i++) edges += 32'(q[i] ^ q[i+1]);
    legal = (edges <= 1);
  end

  // Ring register: reset, self-correct, load, step, hold in priority order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       q <= '0;
    else if (!legal)  q <= '0;
    else if (load)    q <= pattern_of(load_phase);
    else if (en)      q <= up ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
  end

  // Flag for the cycle following an edge that saw an illegal pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal <= 1'b0;
    else        illegal <= ~legal;
  end
`else
  // Ring register: reset, load, step, hold in priority order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       q <= '0;
    else if (load)    q <= pattern_of(load_phase);
    else if (en)      q <= up ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
  end

  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed self-checking bench for johnson_counter_param (WIDTH=4 main
// instance, WIDTH=3 instance for out-of-range load phases).
module tb_johnson_counter_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, load;
  logic [2:0] load_phase;
  logic [3:0] q;
  logic [2:0] phase;
  logic [7:0] dec;
  logic       tc, illegal;

  logic       en3, up3, load3;
  logic [2:0] load_phase3;
  logic [2:0] q3;
  logic [2:0] phase3;
  logic [5:0] dec3;
  logic       tc3, illegal3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  johnson_counter_param #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_phase(load_phase), .q(q), .phase(phase), .dec(dec),
    .tc(tc), .illegal(illegal)
  );

  johnson_counter_param #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .up(up3), .load(load3),
    .load_phase(load_phase3), .q(q3), .phase(phase3), .dec(dec3),
    .tc(tc3), .illegal(illegal3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] walk_q  [9];
    logic [2:0] walk_ph [9];
    walk_q  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
    walk_ph = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_phase = '0;
    en3 = 1'b0; up3 = 1'b1; load3 = 1'b0; load_phase3 = '0;

    // Reset state
    #2;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_dec", 32'(dec), 32'h01);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_tc_idle", 32'(tc), 32'd0);
    en = 1'b1; up = 1'b0;
    #1;
    chk("rst_tc_down", 32'(tc), 32'd1);
    up = 1'b1;
    #1;
    chk("rst_tc_up", 32'(tc), 32'd0);
    #8 reset = 1'b1;

    // Up walk through a full wrap
    for (int i = 0; i < 9; i++) begin
      step();
      chk("up_q", 32'(q), 32'(walk_q[i]));
      chk("up_phase", 32'(phase), 32'(walk_ph[i]));
      chk("up_tc", 32'(tc), (walk_ph[i] == 3'd7) ? 32'd1 : 32'd0);
      if (i == 6) chk("up_dec7", 32'(dec), 32'h80);
    end

    // Asynchronous reset mid-count
    step(); step();
    chk("pre_rst_q", 32'(q), 32'h7);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_q", 32'(q), 32'h0);
    chk("async_rst_phase", 32'(phase), 32'd0);
    chk("async_rst_dec", 32'(dec), 32'h01);
    reset = 1'b1;

    // Down from 0
    up = 1'b0;
    #1;
    chk("down_tc0", 32'(tc), 32'd1);
    step();
    chk("down_q1", 32'(q), 32'h8);
    chk("down_ph1", 32'(phase), 32'd7);
    chk("down_tc1", 32'(tc), 32'd0);
    step(); chk("down_q2", 32'(q), 32'hC);
    step(); chk("down_q3", 32'(q), 32'hE);
    step(); chk("down_q4", 32'(q), 32'hF);
    step(); chk("down_q5", 32'(q), 32'h7);
    chk("down_ph5", 32'(phase), 32'd3);

    // Direction reversals, no dead cycle
    up = 1'b1; step();
    chk("rev_up_ph", 32'(phase), 32'd4);
    up = 1'b0; step();
    chk("rev_dn_ph", 32'(phase), 32'd3);
    step();
    chk("rev_dn2_q", 32'(q), 32'h3);
    up = 1'b1; step();
    chk("rev_up2_ph", 32'(phase), 32'd3);
    up = 1'b0; step();
    chk("rev_at3_q", 32'(q), 32'h3);
    chk("rev_at3_ph", 32'(phase), 32'd2);

    // Load beats enable
    load = 1'b1; load_phase = 3'd5; up = 1'b1;
    #1;
    chk("load_tc", 32'(tc), 32'd0);
    step();
    chk("load5_q", 32'(q), 32'hE);
    chk("load5_ph", 32'(phase), 32'd5);
    chk("load5_dec", 32'(dec), 32'h20);
    load_phase = 3'd0; step();
    chk("load0_q", 32'(q), 32'h0);
    load_phase = 3'd7; step();
    chk("load7_q", 32'(q), 32'h8);
    load_phase = 3'd4; en = 1'b0; step();
    chk("load4_q", 32'(q), 32'hF);
    load = 1'b0;

    // Hold at phase 4
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_q", 32'(q), 32'hF);
      chk("hold_tc", 32'(tc), 32'd0);
    end

    // Out-of-range load phases on the WIDTH=3 instance (6 states)
    load3 = 1'b1; en3 = 1'b1;
    load_phase3 = 3'd4; step(); chk("w3_load4_q", 32'(q3), 32'h6);
    load_phase3 = 3'd6; step(); chk("w3_load6_q", 32'(q3), 32'h0);
    load_phase3 = 3'd4; step(); chk("w3_reload4_q", 32'(q3), 32'h6);
    load_phase3 = 3'd7; step(); chk("w3_load7_q", 32'(q3), 32'h0);
    load3 = 1'b0; en3 = 1'b0;

    // Illegal pattern injection
    force dut.q = 4'b0101;
    #1 release dut.q;
    en = 1'b1; up = 1'b1; load = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
    step();
    chk("sc_q", 32'(q), 32'h0);
    chk("sc_illegal", 32'(illegal), 32'd1);
    step();
    chk("sc_q_next", 32'(q), 32'h1);
    chk("sc_illegal_clr", 32'(illegal), 32'd0);
`else
    step();
    chk("ill_q1", 32'(q), 32'hB);
    chk("ill_flag1", 32'(illegal), 32'd0);
    step();
    chk("ill_q2", 32'(q), 32'h6);
    chk("ill_flag2", 32'(illegal), 32'd0);
`endif
    load = 1'b1; load_phase = 3'd2; step();
    chk("recover_q", 32'(q), 32'h3);
    chk("recover_illegal", 32'(illegal), 32'd0);
    load = 1'b0; en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
